mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single MMU memory port (req/addr/we/be/wdata in; rvalid/err/rdata back) between NUM_REQ requesters, e.g. Ibex instruction fetch, Ibex data and the Vicuna vector unit.
- Arbitration is round-robin.
- Exactly one transaction is outstanding at a time.
- Each request is latched and held on the MMU port until the MMU completes it or a timeout expires.
- The response is then routed back to the winning requester only.
- Sits between the cores and mmu, at the top level.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 bits
TIMEOUT, 64, ISSUE cycles without completion before a forced error (≥2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-requester request
addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester n uses slice n
we_i  in  NUM_REQ  write enable (1 = write)
be_i  in  NUM_REQ*DATA_W/8  packed byte enables
wdata_i  in  NUM_REQ*DATA_W  packed write data
gnt_o  out  NUM_REQ  one-hot acceptance pulse
rvalid_o  out  NUM_REQ  one-hot completion pulse
err_o  out  1  error flag, valid while any rvalid_o bit is set
rdata_o  out  DATA_W  read data, valid while any rvalid_o bit is set
mem_req_o  out  1  request to mmu
mem_addr_o  out  ADDR_W  address to mmu
mem_we_o  out  1  write enable to mmu
mem_be_o  out  DATA_W/8  byte enables to mmu
mem_wdata_o  out  DATA_W  write data to mmu
mem_rvalid_i  in  1  mmu completion
mem_err_i  in  1  mmu error (completes the transaction even without rvalid)
mem_rdata_i  in  DATA_W  mmu read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- States are IDLE, ISSUE and RESP.
- IDLE:
  - gnt_o is combinational: a one-hot select of the first set req_i bit, searching from pointer upward with wrap.
  - On the edge where gnt_o is set, the winner's addr/we/be/wdata and index are latched, the pointer becomes winner+1 mod NUM_REQ, and the state goes to ISSUE.
  - With no request, the block stays in IDLE.
  - A requester may drop req_i in the cycle after gnt_o.
- ISSUE:
  - mem_req_o = 1 and the mem_* outputs drive the latched values, held stable for the whole state.
  - The counter increments each cycle.
  - Completion when mem_rvalid_i or mem_err_i is sampled high: latch rdata_o = mem_rdata_i and err_o = mem_err_i, then go to RESP.
  - Timeout when the counter reaches TIMEOUT-1 without completion: latch rdata_o = 0 and err_o = 1, then go to RESP.
  - On the edge where completion and timeout coincide, completion wins.
- RESP:
  - mem_req_o = 0.
  - rvalid_o[winner] = 1 for exactly one cycle, carrying err_o and rdata_o.
  - Counter cleared, then go to IDLE.
  - No grant is issued in RESP, which guarantees at least one idle cycle on mem_req_o between transactions.
- Outside RESP: rvalid_o = 0, err_o = 0, rdata_o = 0.
- Latency: grant in cycle 0, mem_req_o high from cycle 1. If the mmu completes in cycle k, rvalid_o is high in cycle k+1 and a new grant is possible from cycle k+2. Minimum period is 3 cycles per transaction.
- Writes and reads are handled identically; the mmu must signal rvalid or err for both.
- Inputs in ISSUE/RESP: req_i changes are ignored, and pending requesters wait without gnt.
- Reset mid-transaction: outputs clear immediately (asynchronous), the in-flight transaction is dropped and no rvalid_o is produced.
- Pointer fairness: with all requesters continuously requesting, the grant order is 0,1,..,NUM_REQ-1,0,…

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum arb_state_e (IDLE, ISSUE, RESP);
  - the request struct mem_req_t {addr, we, be, wdata};
  - the localparam BE_W = DATA_W/8.
- Sub-module rr_pick: combinational round-robin one-hot selector (req vector plus pointer gives one-hot grant and index). The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- Single read: req_i = 01, addr 0x0000_1004; mmu returns rvalid with rdata 0xDEAD_BEEF 3 cycles after mem_req_o rises -> gnt_o = 01 in cycle 0; mem_addr_o = 0x1004 held for cycles 1..4; rvalid_o = 01 with rdata_o = 0xDEAD_BEEF and err_o = 0 in cycle 5.
- Contention: both requesters hold req from reset, requester 0 at 0x1000 and requester 1 at 0x1008, mmu answers in 1 cycle -> grants in order 0,1,0,1; mem_req_o drops for ≥1 cycle between transactions; each rvalid_o goes only to its owner.
- Error passthrough: write to 0x0000_0050 with mmu err = 1 and no rvalid -> rvalid_o[winner] = 1, err_o = 1 one cycle later.
- Timeout: mmu never responds, TIMEOUT = 8 -> mem_req_o high for exactly 8 cycles, then rvalid_o = 1, err_o = 1, rdata_o = 0; the next grant proceeds normally.
- Held inputs: requester changes addr_i to 0x2000 during ISSUE of 0x1000 -> mem_addr_o stays 0x1000 throughout.
- Reset mid-op: rst low in the second ISSUE cycle -> all outputs 0 immediately; after release, no stale rvalid_o, pointer 0, and requester 1 alone is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;

    localparam int ADDR_W_MAX = 64;
    localparam int DATA_W_MAX = 64;
    localparam int BE_W       = DATA_W_MAX / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [DATA_W_MAX-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin selector searching upward from ptr_i with wrap
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] pos [N];

    // scan from the farthest offset down so the nearest requester from ptr_i wins
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos[i] = IW'((int'(ptr_i) + i) % N);
            if (req_i[pos[i]]) idx_o = pos[i];
        end
        gnt_o = (|req_i) ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one mmu port, one transaction in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     addr_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] be_i,
    input  logic [NUM_REQ*DATA_W-1:0]     wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic                          err_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          mem_req_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic                          mem_we_o,
    output logic [DATA_W/8-1:0]           mem_be_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic                          mem_rvalid_i,
    input  logic                          mem_err_i,
    input  logic [DATA_W-1:0]             mem_rdata_i
);

    localparam int BYTE_W = DATA_W / 8;
    localparam int IW     = $clog2(NUM_REQ);
    localparam int CW     = $clog2(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // state register; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // next state: grant and latch in IDLE, wait for completion or timeout in ISSUE
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (|req_i) begin
                state_d     = ISSUE;
                idx_d       = pick_idx;
                ptr_d       = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                cnt_d       = '0;
                req_d.addr  = ADDR_W_MAX'(addr_i[pick_idx*ADDR_W +: ADDR_W]);
                req_d.we    = we_i[pick_idx];
                req_d.be    = BE_W'(be_i[pick_idx*BYTE_W +: BYTE_W]);
                req_d.wdata = DATA_W_MAX'(wdata_i[pick_idx*DATA_W +: DATA_W]);
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid_i || mem_err_i) begin
                    state_d = RESP;
                    rdata_d = mem_rdata_i;
                    err_d   = mem_err_i;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are gated by state so nothing stale leaks outside ISSUE/RESP
    always_comb begin
        gnt_o       = (state_q == IDLE && rst) ? pick_gnt : '0;
        rvalid_o    = (state_q == RESP) ? (NUM_REQ'(1) << idx_q) : '0;
        err_o       = (state_q == RESP) ? err_q : 1'b0;
        rdata_o     = (state_q == RESP) ? rdata_q : '0;
        mem_req_o   = (state_q == ISSUE);
        mem_addr_o  = (state_q == ISSUE) ? req_q.addr[ADDR_W-1:0] : '0;
        mem_we_o    = (state_q == ISSUE) ? req_q.we : 1'b0;
        mem_be_o    = (state_q == ISSUE) ? req_q.be[BYTE_W-1:0] : '0;
        mem_wdata_o = (state_q == ISSUE) ? req_q.wdata[DATA_W-1:0] : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions against a transaction-level model
module tb_mem_port_arbiter;

    localparam int NR  = 2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_i;
    logic [63:0]   addr_i;
    logic [1:0]    we_i;
    logic [7:0]    be_i;
    logic [63:0]   wdata_i;
    logic [1:0]    gnt_o;
    logic [1:0]    rvalid_o;
    logic          err_o;
    logic [31:0]   rdata_o;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_rvalid_i;
    logic          mem_err_i;
    logic [31:0]   mem_rdata_i;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int ptr    = 0;

    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        w [2];
    logic [3:0]  b [2];

    mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_err_i    (mem_err_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        addr_i  = {a[1], a[0]};
        we_i    = {w[1], w[0]};
        be_i    = {b[1], b[0]};
        wdata_i = {d[1], d[0]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // j = ISSUE cycle (1-based) in which the mmu answers; j outside 1..TMO means never
    task automatic run_txn(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                           input logic w0, input logic w1, input int j,
                           input logic rsp_v, input logic rsp_e, input logic [31:0] rdat);
        int          win;
        bit          found;
        bit          to;
        int          done;
        logic [31:0] ea, ed, rd;
        logic        ew;
        logic [3:0]  eb;
        a[0] = a0;
        a[1] = a1;
        w[0] = w0;
        w[1] = w1;
        for (int i = 0; i < NR; i++) begin
            d[i] = $urandom;
            b[i] = 4'($urandom);
        end
        drive();
        req_i = rv;
        found = 0;
        win   = 0;
        for (int i = 0; i < NR; i++)
            if (!found && ((rv >> ((ptr + i) % NR)) & 2'b01) != 0) begin
                win   = (ptr + i) % NR;
                found = 1;
            end
        ea = a[win];
        ed = d[win];
        ew = w[win];
        eb = b[win];
        #1;
        chk("gnt", gnt_o, 64'(1) << win);
        step();
        ptr  = (win + 1) % NR;
        to   = (j < 1 || j > TMO);
        done = to ? TMO : j;
        rd   = '0;
        for (int c = 1; c <= done; c++) begin
            if (c == 2) begin
                a[0] = 32'h2000;
                a[1] = $urandom;
                d[0] = $urandom;
                d[1] = $urandom;
                w[0] = ~w[0];
                w[1] = ~w[1];
                drive();
                req_i = 2'($urandom);
            end
            chk("mem_req", mem_req_o, 1);
            chk("mem_addr", mem_addr_o, ea);
            chk("mem_wdata", mem_wdata_o, ed);
            chk("mem_we", mem_we_o, ew);
            chk("mem_be", mem_be_o, eb);
            chk("gnt_busy", gnt_o, 0);
            chk("rvalid_busy", rvalid_o, 0);
            chk("err_busy", err_o, 0);
            rd           = (c == j) ? rdat : $urandom;
            mem_rdata_i  = rd;
            mem_rvalid_i = (c == j) && rsp_v;
            mem_err_i    = (c == j) && rsp_e;
            step();
        end
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        req_i        = 2'b11;
        #1;
        chk("rvalid", rvalid_o, 64'(1) << win);
        chk("err", err_o, to ? 1 : rsp_e);
        chk("rdata", rdata_o, to ? 0 : rd);
        chk("mem_req_resp", mem_req_o, 0);
        chk("gnt_resp", gnt_o, 0);
        step();
        chk("rvalid_after", rvalid_o, 0);
        chk("mem_req_idle", mem_req_o, 0);
        chk("rdata_idle", rdata_o, 0);
        req_i = 2'b00;
    endtask

    initial begin
        rst          = 1'b0;
        req_i        = 2'b11;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            d[i] = '0;
            w[i] = 1'b0;
            b[i] = '0;
        end
        drive();
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        step();
        rst = 1'b1;
        // contention from reset: expect 0,1,0,1
        for (int k = 0; k < 4; k++)
            run_txn(2'b11, 32'h1000, 32'h1008, 1'b0, 1'b0, 1, 1'b1, 1'b0, $urandom);
        // single read, mmu answers 3 cycles after mem_req rises
        run_txn(2'b01, 32'h0000_1004, $urandom, 1'b0, 1'b0, 4, 1'b1, 1'b0, 32'hDEAD_BEEF);
        // error passthrough on a write without rvalid
        run_txn(2'b01, 32'h0000_0050, $urandom, 1'b1, 1'b0, 1, 1'b0, 1'b1, $urandom);
        // timeout, then a normal transaction
        run_txn(2'b10, $urandom, $urandom, 1'b0, 1'b0, 0, 1'b0, 1'b0, $urandom);
        run_txn(2'b01, $urandom, $urandom, 1'b0, 1'b1, 2, 1'b1, 1'b0, $urandom);
        // completion on the final allowed cycle beats the timeout
        run_txn(2'b11, $urandom, $urandom, 1'b1, 1'b0, TMO, 1'b1, 1'b0, $urandom);
        // reset in the second ISSUE cycle after granting requester 0
        a[0] = 32'h1000;
        drive();
        req_i = 2'b01;
        #1;
        chk("mid_gnt", gnt_o, 1);
        step();
        step();
        chk("mid_issue", mem_req_o, 1);
        rst = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        chk("mid_mem_req", mem_req_o, 0);
        chk("mid_mem_addr", mem_addr_o, 0);
        chk("mid_gnt_rst", gnt_o, 0);
        chk("mid_rvalid", rvalid_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        req_i = 2'b00;
        rst   = 1'b1;
        ptr   = 0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_rvalid", rvalid_o, 0);
            chk("post_rst_mem_req", mem_req_o, 0);
            step();
        end
        req_i = 2'b11;
        #1;
        chk("post_rst_ptr", gnt_o, 1);
        run_txn(2'b10, $urandom, $urandom, 1'b0, 1'b0, 1, 1'b1, 1'b0, $urandom);
        // random traffic
        for (int k = 0; k < 40; k++) begin
            logic v;
            v = 1'($urandom);
            run_txn(2'($urandom_range(1, 3)), $urandom, $urandom, 1'($urandom), 1'($urandom),
                    $urandom_range(0, TMO + 2), v, v ? 1'($urandom) : 1'b1, $urandom);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
